// File: rtl/sensor_scanner_pkg.sv
// Shared types and constants for the sensor scanner: FSM states,
// sensor count, reading width and the default request timeout.
package sensor_scanner_pkg;

  localparam int SENSOR_COUNT           = 4;
  localparam int SENSOR_W               = 8;
  localparam int SEL_W                  = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_GAP     = 2'd2,
    ST_DONE    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/sensor_scanner_if.sv
// Shared request/acknowledge bus between the scanner (master) and the
// selected height sensor (slave). Data is valid in the same cycle as ack.
interface sensor_scanner_if;
  import sensor_scanner_pkg::*;

  logic [SEL_W-1:0]    sample_sel;
  logic                sample_req;
  logic                sample_ack;
  logic [SENSOR_W-1:0] sample_data;

  modport master (
    output sample_sel,
    output sample_req,
    input  sample_ack,
    input  sample_data
  );

  modport slave (
    input  sample_sel,
    input  sample_req,
    output sample_ack,
    output sample_data
  );

endinterface

// File: rtl/sensor_scanner_scan_timeout_counter.sv
// Counts REQUEST cycles without an acknowledge. expired is high in the
// cycle where the count has reached LIMIT-1, i.e. the LIMIT-th cycle of
// a request, so a request dwells at most LIMIT cycles.
module scan_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  // Restart on clear, otherwise step once per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/sensor_scanner.sv
// Sequential acquisition front-end: polls four height sensors over a shared
// req/ack bus, gathers one reading each into shadow registers and publishes
// the whole frame atomically on sensor1..sensor4 with a frame_valid pulse.
// A sensor that does not answer in time reads as 0 and gets its flag set.
// Optional macro SENSOR_SCANNER_RETRY_EN: a first timeout on a sensor is
// followed by one GAP cycle and a second request of the same sensor; only a
// second consecutive timeout substitutes 0.
module sensor_scanner
  import sensor_scanner_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter bit          CONTINUOUS     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  sensor_scanner_if.master        bus,
  output logic [SENSOR_W-1:0]     sensor1,
  output logic [SENSOR_W-1:0]     sensor2,
  output logic [SENSOR_W-1:0]     sensor3,
  output logic [SENSOR_W-1:0]     sensor4,
  output logic                    frame_valid,
  output logic [SENSOR_COUNT-1:0] timeout_flags
);

  scan_state_t state;
  logic [SEL_W-1:0] sel;
  logic             req;
  logic [SENSOR_COUNT-1:0][SENSOR_W-1:0] shadow;
  logic [SENSOR_COUNT-1:0]               shadow_flags;
  logic             tmo_clear;
  logic             tmo_enable;
  logic             tmo_expired;
  logic             transfer;
`ifdef SENSOR_SCANNER_RETRY_EN
  logic             retried;
  logic             retry_gap;
`endif

  assign bus.sample_sel = sel;
  assign bus.sample_req = req;

  // A transfer needs both sides; an ack outside REQUEST is ignored.
  assign transfer   = (state == ST_REQUEST) && bus.sample_ack;
  assign tmo_clear  = (state != ST_REQUEST);
  assign tmo_enable = (state == ST_REQUEST) && !bus.sample_ack;

  scan_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Scan FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      req           <= 1'b0;
      sel           <= '0;
      frame_valid   <= 1'b0;
      sensor1       <= '0;
      sensor2       <= '0;
      sensor3       <= '0;
      sensor4       <= '0;
      timeout_flags <= '0;
      shadow        <= '0;
      shadow_flags  <= '0;
`ifdef SENSOR_SCANNER_RETRY_EN
      retried       <= 1'b0;
      retry_gap     <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_REQUEST;
            busy  <= 1'b1;
            req   <= 1'b1;
            sel   <= '0;
          end
        end

        ST_REQUEST: begin
          if (transfer) begin
            shadow[sel]       <= bus.sample_data;
            shadow_flags[sel] <= 1'b0;
            state             <= ST_GAP;
            req               <= 1'b0;
          end else if (tmo_expired) begin
`ifdef SENSOR_SCANNER_RETRY_EN
            if (!retried) begin
              retried   <= 1'b1;
              retry_gap <= 1'b1;
            end else begin
              shadow[sel]       <= '0;
              shadow_flags[sel] <= 1'b1;
            end
`else
            shadow[sel]       <= '0;
            shadow_flags[sel] <= 1'b1;
`endif
            state <= ST_GAP;
            req   <= 1'b0;
          end
        end

        ST_GAP: begin
`ifdef SENSOR_SCANNER_RETRY_EN
          if (retry_gap) begin
            retry_gap <= 1'b0;
            state     <= ST_REQUEST;
            req       <= 1'b1;
          end else
`endif
          if (sel == SEL_W'(SENSOR_COUNT - 1)) begin
`ifdef SENSOR_SCANNER_RETRY_EN
            retried       <= 1'b0;
`endif
            state         <= ST_DONE;
            frame_valid   <= 1'b1;
            sensor1       <= shadow[0];
            sensor2       <= shadow[1];
            sensor3       <= shadow[2];
            sensor4       <= shadow[3];
            timeout_flags <= shadow_flags;
          end else begin
`ifdef SENSOR_SCANNER_RETRY_EN
            retried <= 1'b0;
`endif
            sel   <= sel + SEL_W'(1);
            state <= ST_REQUEST;
            req   <= 1'b1;
          end
        end

        ST_DONE: begin
          if (CONTINUOUS) begin
            state <= ST_REQUEST;
            req   <= 1'b1;
            sel   <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed testbench for sensor_scanner: a bench-side sensor model answers
// each request after a programmed delay, and every frame is checked against
// hand-computed readings, flags and cycle counts.
module tb_sensor_scanner;
  import sensor_scanner_pkg::*;

`ifdef SENSOR_SCANNER_RETRY_EN
  localparam int TMO_FRAME_CYCLES = 41;
  localparam int TMO_REQ_CYCLES   = 32;
`else
  localparam int TMO_FRAME_CYCLES = 24;
  localparam int TMO_REQ_CYCLES   = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_c;
  logic busy, busy_c;
  logic frame_valid, frame_valid_c;
  logic [7:0] s1, s2, s3, s4;
  logic [7:0] c1, c2, c3, c4;
  logic [3:0] flags, flags_c;

  int checks = 0;
  int errors = 0;

  int       ack_delay [4];
  logic [7:0] ack_data [4];
  bit       miss_first [4];
  int       req_hi_cnt [4];
  int       seq [$];
  int       rc;
  int       attempt;
  int       last_sel;
  bit       prev_req;
  bit       stray_ack;

  sensor_scanner_if bus ();
  sensor_scanner_if bus_c ();

  always #5 clk = ~clk;

  sensor_scanner #(
    .TIMEOUT_CYCLES (16),
    .CONTINUOUS     (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .bus           (bus),
    .sensor1       (s1),
    .sensor2       (s2),
    .sensor3       (s3),
    .sensor4       (s4),
    .frame_valid   (frame_valid),
    .timeout_flags (flags)
  );

  sensor_scanner #(
    .TIMEOUT_CYCLES (16),
    .CONTINUOUS     (1'b1)
  ) dut_c (
    .clk           (clk),
    .rst           (rst),
    .start         (start_c),
    .busy          (busy_c),
    .bus           (bus_c),
    .sensor1       (c1),
    .sensor2       (c2),
    .sensor3       (c3),
    .sensor4       (c4),
    .frame_valid   (frame_valid_c),
    .timeout_flags (flags_c)
  );

  // Sensor model: acks the selected sensor after its programmed delay.
  always @(negedge clk) begin
    if (bus.sample_req) begin
      if (!prev_req) begin
        if (int'(bus.sample_sel) == last_sel) attempt = attempt + 1;
        else attempt = 0;
        last_sel = int'(bus.sample_sel);
        seq.push_back(int'(bus.sample_sel));
        rc = 0;
      end else begin
        rc = rc + 1;
      end
      req_hi_cnt[bus.sample_sel] = req_hi_cnt[bus.sample_sel] + 1;
      if (ack_delay[bus.sample_sel] == rc &&
          !(miss_first[bus.sample_sel] && attempt == 0)) begin
        bus.sample_ack  = 1'b1;
        bus.sample_data = ack_data[bus.sample_sel];
      end else begin
        bus.sample_ack  = 1'b0;
        bus.sample_data = 8'h00;
      end
    end else begin
      bus.sample_ack  = stray_ack;
      bus.sample_data = stray_ack ? 8'hEE : 8'h00;
    end
    prev_req = bus.sample_req;
  end

  // Second sensor model: always answers at once with full scale.
  always @(negedge clk) begin
    bus_c.sample_ack  = bus_c.sample_req;
    bus_c.sample_data = 8'hFF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setFrame(input int d0, input int d1, input int d2, input int d3,
                          input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    ack_delay[0] = d0; ack_delay[1] = d1; ack_delay[2] = d2; ack_delay[3] = d3;
    ack_data[0]  = v0; ack_data[1]  = v1; ack_data[2]  = v2; ack_data[3]  = v3;
  endtask

  // Pulses start and returns the cycle index (1 = first after the start
  // edge) in which frame_valid appears, or -1 if it never does.
  task automatic applyStimulus(input bit extra_starts, output int cycles);
    for (int i = 0; i < 4; i++) req_hi_cnt[i] = 0;
    seq.delete();
    last_sel = -1;
    attempt  = 0;
    cycles   = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = extra_starts && (c == 3 || c == 7);
      if (frame_valid) begin
        cycles = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  function automatic logic [31:0] packed_out();
    return {s4, s3, s2, s1};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int pulses [$];
    int fv_count;

    rst = 1'b1; start = 1'b0; start_c = 1'b0; stray_ack = 1'b0;
    prev_req = 1'b0; rc = 0; attempt = 0; last_sel = -1;
    for (int i = 0; i < 4; i++) begin
      miss_first[i] = 1'b0; req_hi_cnt[i] = 0;
    end
    setFrame(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req", 32'(bus.sample_req), 32'd0);
    checkOutput("reset_sel", 32'(bus.sample_sel), 32'd0);
    checkOutput("reset_fv", 32'(frame_valid), 32'd0);
    checkOutput("reset_sensors", packed_out(), 32'h0);
    checkOutput("reset_flags", 32'(flags), 32'h0);

    $display("[TB] frame with immediate acks");
    setFrame(0, 0, 0, 0, 8'd10, 8'd20, 8'd30, 8'd40);
    applyStimulus(1'b0, cyc);
    checkOutput("basic_latency", 32'(cyc), 32'd9);
    checkOutput("basic_sensors", packed_out(), 32'h281E140A);
    checkOutput("basic_flags", 32'(flags), 32'h0);
    @(negedge clk);
    checkOutput("basic_fv_one_cycle", 32'(frame_valid), 32'd0);
    checkOutput("basic_busy_low", 32'(busy), 32'd0);

    $display("[TB] sensor 2 never answers");
    setFrame(0, 0, -1, 0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    applyStimulus(1'b0, cyc);
    checkOutput("tmo_latency", 32'(cyc), 32'(TMO_FRAME_CYCLES));
    checkOutput("tmo_req_cycles", 32'(req_hi_cnt[2]), 32'(TMO_REQ_CYCLES));
    checkOutput("tmo_sensors", packed_out(), 32'hD400B2A1);
    checkOutput("tmo_flags", 32'(flags), 32'h4);

    $display("[TB] ack on the last allowed request cycle");
    setFrame(0, 15, 0, 0, 8'h01, 8'h55, 8'h03, 8'h04);
    applyStimulus(1'b0, cyc);
    checkOutput("edge_latency", 32'(cyc), 32'd24);
    checkOutput("edge_sensors", packed_out(), 32'h04035501);
    checkOutput("edge_flags", 32'(flags), 32'h0);

    $display("[TB] stray acks in GAP and extra start pulses");
    stray_ack = 1'b1;
    setFrame(0, 2, 1, 3, 8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(1'b1, cyc);
    stray_ack = 1'b0;
    checkOutput("stray_latency", 32'(cyc), 32'd15);
    checkOutput("stray_sensors", packed_out(), 32'h44332211);
    checkOutput("stray_flags", 32'(flags), 32'h0);
    checkOutput("stray_seq_len", 32'(seq.size()), 32'd4);
    if (seq.size() == 4)
      checkOutput("stray_seq", 32'({seq[3][1:0], seq[2][1:0], seq[1][1:0], seq[0][1:0]}),
                  32'hE4);
    fv_count = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_valid) fv_count++;
    end
    checkOutput("stray_no_extra_frame", 32'(fv_count), 32'd0);
    checkOutput("stray_idle", 32'(busy), 32'd0);

    $display("[TB] reset in the middle of a frame");
    setFrame(0, 0, 0, 0, 8'h05, 8'h06, 8'h07, 8'h08);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_req", 32'(bus.sample_req), 32'd0);
    checkOutput("midrst_sel", 32'(bus.sample_sel), 32'd0);
    checkOutput("midrst_sensors", packed_out(), 32'h0);
    checkOutput("midrst_flags", 32'(flags), 32'h0);
    fv_count = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (frame_valid) fv_count++;
    end
    checkOutput("midrst_no_frame", 32'(fv_count), 32'd0);
    setFrame(0, 0, 0, 0, 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1'b0, cyc);
    checkOutput("fresh_latency", 32'(cyc), 32'd9);
    checkOutput("fresh_sensors", packed_out(), 32'h04030201);
    checkOutput("fresh_flags", 32'(flags), 32'h0);

    $display("[TB] continuous scanning");
    @(negedge clk);
    start_c = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (frame_valid_c) pulses.push_back(c);
    end
    checkOutput("cont_pulse_count", 32'(pulses.size()), 32'd5);
    for (int i = 0; i < pulses.size() && i < 5; i++)
      checkOutput($sformatf("cont_pulse_%0d", i), 32'(pulses[i]), 32'(9 * (i + 1)));
    checkOutput("cont_sensors", {c4, c3, c2, c1}, 32'hFFFFFFFF);
    checkOutput("cont_flags", 32'(flags_c), 32'h0);
    checkOutput("cont_busy", 32'(busy_c), 32'd1);

`ifdef SENSOR_SCANNER_RETRY_EN
    $display("[TB] retry after a missed first attempt");
    miss_first[0] = 1'b1;
    setFrame(0, 0, 0, 0, 8'h99, 8'h01, 8'h02, 8'h03);
    applyStimulus(1'b0, cyc);
    miss_first[0] = 1'b0;
    checkOutput("retry_latency", 32'(cyc), 32'd26);
    checkOutput("retry_req_cycles", 32'(req_hi_cnt[0]), 32'd17);
    checkOutput("retry_sensors", packed_out(), 32'h03020199);
    checkOutput("retry_flags", 32'(flags), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
